// File: rtl/reg_file_sb.sv
// reg_file_sb: register file with two registered read ports, one write port and a busy scoreboard.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data to matching reads.
module reg_file_sb #(
  parameter int DATA_W = 8,
  parameter int NUM_REGS = 4,
  parameter int ADDR_W = 2
) (
  input  logic                       clk,
  input  logic                       reset_,
  input  logic                       rd_en_0,
  input  logic [ADDR_W-1:0]          rd_sel_0,
  output logic [DATA_W-1:0]          rd_data_0,
  output logic                       rd_stall_0,
  input  logic                       rd_en_1,
  input  logic [ADDR_W-1:0]          rd_sel_1,
  output logic [DATA_W-1:0]          rd_data_1,
  output logic                       rd_stall_1,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_sel,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rsv_en,
  input  logic [ADDR_W-1:0]          rsv_sel,
  output logic                       rsv_conflict,
  output logic [NUM_REGS-1:0]        busy,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat
);
`ifdef REG_FILE_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(NUM_REGS);
  logic [DATA_W-1:0] mem [NUM_REGS];
  logic [DATA_W-1:0] view [DEPTH];
  logic [DEPTH-1:0] busy_x;
  logic [NUM_REGS-1:0] wr_dec, rsv_dec;
  logic wr_ok, rsv_ok, conflict_n;
  logic [1:0] rd_en, in_rng, byp, stall_q;
  logic [ADDR_W-1:0] rd_sel [2];
  logic [DATA_W-1:0] rd_q [2];
  assign wr_ok = wr_en && {1'b0, wr_sel} < LIMIT;
  assign rsv_ok = rsv_en && {1'b0, rsv_sel} < LIMIT;
  assign busy_x = DEPTH'(busy);
  // a write landing on the same register in the same cycle absorbs the conflict
  assign conflict_n = rsv_ok && busy_x[rsv_sel] && !(wr_ok && wr_sel == rsv_sel);
  assign rd_en = {rd_en_1, rd_en_0};
  assign rd_sel[0] = rd_sel_0;
  assign rd_sel[1] = rd_sel_1;
  assign rd_data_0 = rd_q[0];
  assign rd_data_1 = rd_q[1];
  assign rd_stall_0 = stall_q[0];
  assign rd_stall_1 = stall_q[1];
  for (genvar i = 0; i < DEPTH; i++) begin : g_view
    if (i < NUM_REGS) begin : g_in
      assign view[i] = mem[i];
      assign regs_flat[i*DATA_W +: DATA_W] = mem[i];
    end else begin : g_out
      assign view[i] = '0;
    end
  end
  always_comb begin
    wr_dec = '0;
    rsv_dec = '0;
    in_rng = '0;
    byp = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_dec[i] = wr_ok && wr_sel == ADDR_W'(i);
      rsv_dec[i] = rsv_ok && rsv_sel == ADDR_W'(i);
    end
    for (int k = 0; k < 2; k++) begin
      in_rng[k] = {1'b0, rd_sel[k]} < LIMIT;
      byp[k] = BYP && wr_ok && rd_sel[k] == wr_sel;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
      busy <= '0;
      rsv_conflict <= 1'b0;
      rd_q[0] <= '0;
      rd_q[1] <= '0;
      stall_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) if (wr_dec[i]) mem[i] <= wr_data;
      busy <= (busy & ~wr_dec) | rsv_dec;
      rsv_conflict <= conflict_n;
      for (int k = 0; k < 2; k++) begin
        rd_q[k] <= (!rd_en[k] || !in_rng[k]) ? '0 : byp[k] ? wr_data :
                   busy_x[rd_sel[k]] ? '0 : view[rd_sel[k]];
        stall_q[k] <= rd_en[k] && in_rng[k] && !byp[k] && busy_x[rd_sel[k]];
      end
    end
  end
endmodule
